uart_tx_fifo: RTL and testbench

//  Byte FIFO between memory_access (UART MMIO store) and uart_tx; decouples single-cycle core stores from 115200-baud serialisation.

---
 rtl/uart_tx_fifo_pkg.sv | 18 +
 rtl/uart_fifo_ptr.sv | 49 ++++
 rtl/uart_tx_fifo.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo_pkg
// Purpose : Constants shared by the UART transmit path: byte width, default
//           transmit FIFO depth and the UART MMIO store address decoded by
//           memory_access.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package uart_tx_fifo_pkg;

  localparam int          UART_BYTE_W     = 8;
  localparam int          UART_FIFO_DEPTH = 16;
  localparam int          UART_FIFO_AW    = 4;
  localparam logic [31:0] UART_MMIO_ADDR  = 32'h1000_0000;

endpackage : uart_tx_fifo_pkg
`default_nettype wire

// File: rtl/uart_fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module  : uart_fifo_ptr
// Purpose : ADDR_W+1 bit FIFO pointer register. The extra MSB distinguishes
//           full from empty when read and write indices coincide; the pointer
//           wraps naturally through 2*DEPTH.
// Ports   : clk, rst      clock, asynchronous active-high reset
//           clr           synchronous clear to zero (wins over inc)
//           inc           advance pointer by one at the clock edge
//           ptr           current pointer value
//           ptr_next      value the pointer takes at the next edge
// Rev     : 1.0  initial release
// ============================================================================
module uart_fifo_ptr #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W:0]   ptr,
  output logic [ADDR_W:0]   ptr_next
);

  logic [ADDR_W:0] ptr_q;
  logic [ADDR_W:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr      = ptr_q;
  assign ptr_next = ptr_d;

endmodule : uart_fifo_ptr
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo
// Purpose : First-word-fall-through byte FIFO between the UART MMIO store
//           path and uart_tx. Absorbs bursts of printed bytes while the
//           serialiser is busy; valid/ready handshake toward uart_tx.
// Config  : define UART_TX_FIFO_OVF_EN to add the ovf_cnt port, an 8-bit
//           saturating count of pushes dropped because the FIFO was full.
// Ports   : clk, rst        clock, asynchronous active-high reset
//           wr_en, wr_data  push strobe and byte
//           flush           synchronous clear of all entries
//           tx_data         registered head byte
//           tx_data_valid   registered "FIFO not empty"
//           tx_data_ready   uart_tx accepts the head byte this cycle
//           full, empty     occupancy flags
//           level           occupancy 0..DEPTH
//           ovf_cnt         dropped-push count (UART_TX_FIFO_OVF_EN only)
// Rev     : 1.0  initial release
// ============================================================================
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int ADDR_W = UART_FIFO_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic                   flush,
  output logic [UART_BYTE_W-1:0] tx_data,
  output logic                   tx_data_valid,
  input  logic                   tx_data_ready,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        level
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic [7:0]             ovf_cnt
`endif
);

  logic [UART_BYTE_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   wr_ptr_next;
  logic [ADDR_W:0]   rd_ptr_next;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] rd_idx_next;

  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   pop;
  logic                   push;
  logic                   drop;

  logic [UART_BYTE_W-1:0] tx_data_q;
  logic [UART_BYTE_W-1:0] tx_data_d;
  logic                   tx_data_valid_q;
  logic                   tx_data_valid_d;

  assign wr_idx      = wr_ptr[ADDR_W-1:0];
  assign rd_idx_next = rd_ptr_next[ADDR_W-1:0];

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                      (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  // tx_data_valid_q always mirrors !fifo_empty, so pop needs no extra guard.
  assign pop  = tx_data_valid_q && tx_data_ready && !flush;
  // A pop frees the head slot in the same cycle, so a full FIFO still
  // accepts a push when the head is being consumed.
  assign push = wr_en && (!fifo_full || pop) && !flush;
  assign drop = wr_en && fifo_full && !pop && !flush;

  uart_fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .inc      (push),
    .ptr      (wr_ptr),
    .ptr_next (wr_ptr_next)
  );

  uart_fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .inc      (pop),
    .ptr      (rd_ptr),
    .ptr_next (rd_ptr_next)
  );

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  // The output register is loaded from the post-edge pointer state so a byte
  // pushed into an empty FIFO is visible one cycle later. When this cycle's
  // write lands in the slot that becomes the head, the array does not hold
  // it yet and the incoming byte is forwarded instead.
  always_comb begin
    tx_data_valid_d = (wr_ptr_next != rd_ptr_next);
    tx_data_d       = mem_q[rd_idx_next];
    if (flush) begin
      tx_data_valid_d = 1'b0;
      tx_data_d       = tx_data_q;
    end else if (push && (wr_idx == rd_idx_next)) begin
      tx_data_d = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data_q       <= '0;
      tx_data_valid_q <= 1'b0;
    end else begin
      tx_data_q       <= tx_data_d;
      tx_data_valid_q <= tx_data_valid_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_data_valid_q;
  assign full          = fifo_full;
  assign empty         = fifo_empty;
  assign level         = wr_ptr - rd_ptr;

`ifdef UART_TX_FIFO_OVF_EN
  logic [7:0] ovf_cnt_q;
  logic [7:0] ovf_cnt_d;

  // Saturates at 8'hFF; only rst clears it, flush leaves it alone.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`else
  // Overflowing pushes are silently discarded in this build.
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule : uart_tx_fifo
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_fifo
// Purpose : Self-checking bench for uart_tx_fifo (DEPTH 16): vector table for
//           the basic handshake, directed sequences for fill/overflow,
//           push-while-full, wrap-around streaming, async reset and flush.
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ready;
  logic       full;
  logic       empty;
  logic [4:0] level;
`ifdef UART_TX_FIFO_OVF_EN
  logic [7:0] ovf_cnt;
`endif

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .flush         (flush),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .full          (full),
    .empty         (empty),
    .level         (level)
`ifdef UART_TX_FIFO_OVF_EN
    ,
    .ovf_cnt       (ovf_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic we, input logic [7:0] wd, input logic fl, input logic rdy);
    wr_en         = we;
    wr_data       = wd;
    flush         = fl;
    tx_data_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; tx_data_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic [4:0] el;
    logic       ef;
    logic       ee;
  } vec_t;

  vec_t vt[14];
  logic [7:0] q[$];
  logic [7:0] ovf_save;

  initial begin
    ovf_save = 8'h00;
    // ---- vector table: single byte, hold, pop, bypass push+pop ----
    vt[0] = '{1'b1, 8'h41, 1'b0, 1'b1, 8'h41, 5'd1, 1'b0, 1'b0};
    for (int i = 1; i <= 10; i++)
      vt[i] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 5'd1, 1'b0, 1'b0};
    vt[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1};
    vt[12] = '{1'b1, 8'h42, 1'b0, 1'b1, 8'h42, 5'd1, 1'b0, 1'b0};
    vt[13] = '{1'b1, 8'h43, 1'b1, 1'b1, 8'h43, 5'd1, 1'b0, 1'b0};

    rst = 1'b1;
    do_reset();
    chk("rst_valid", {31'd0, tx_data_valid}, 32'd0);
    chk("rst_data",  {24'd0, tx_data}, 32'h00);
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full",  {31'd0, full}, 32'd0);
`ifdef UART_TX_FIFO_OVF_EN
    chk("rst_ovf",   {24'd0, ovf_cnt}, 32'd0);
`endif

    for (int i = 0; i < 14; i++) begin
      step(vt[i].we, vt[i].wd, 1'b0, vt[i].rdy);
      chk("vec_valid", {31'd0, tx_data_valid}, {31'd0, vt[i].ev});
      if (vt[i].ev) chk("vec_data", {24'd0, tx_data}, {24'd0, vt[i].ed});
      chk("vec_level", {27'd0, level}, {27'd0, vt[i].el});
      chk("vec_full",  {31'd0, full},  {31'd0, vt[i].ef});
      chk("vec_empty", {31'd0, empty}, {31'd0, vt[i].ee});
    end

    // ---- fill to full, overflow drop, ordered drain ----
    do_reset();
    for (int k = 0; k < 16; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
    chk("fill_full",  {31'd0, full}, 32'd1);
    chk("fill_level", {27'd0, level}, 32'd16);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("drop_level", {27'd0, level}, 32'd16);
    chk("drop_head",  {24'd0, tx_data}, 32'h00);
`ifdef UART_TX_FIFO_OVF_EN
    chk("drop_ovf",   {24'd0, ovf_cnt}, 32'd1);
`endif
    for (int k = 0; k < 16; k++) begin
      chk("drain_valid", {31'd0, tx_data_valid}, 32'd1);
      chk("drain_data",  {24'd0, tx_data}, k);
      step(1'b0, 8'h00, 1'b0, 1'b1);
    end
    chk("drain_empty", {31'd0, empty}, 32'd1);
    chk("drain_valid_end", {31'd0, tx_data_valid}, 32'd0);

    // ---- push while full with simultaneous pop ----
    do_reset();
    for (int k = 0; k < 16; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    chk("pp_level", {27'd0, level}, 32'd16);
    chk("pp_full",  {31'd0, full}, 32'd1);
    for (int k = 0; k < 16; k++) begin
      chk("pp_data", {24'd0, tx_data}, (k < 15) ? (k + 1) : 32'h55);
      step(1'b0, 8'h00, 1'b0, 1'b1);
    end
    chk("pp_empty", {31'd0, empty}, 32'd1);

    // ---- streaming with ready toggling 1010.., pointers wrap ----
    do_reset();
    q.delete();
    begin
      int pops = 0;
      int nxt  = 0;
      int cyc  = 0;
      while (pops < 70 && cyc < 400) begin
        logic rdy, can_pop, we;
        logic [7:0] wd;
        rdy     = (cyc % 2 == 0);
        can_pop = (q.size() != 0) && rdy;
        we      = (q.size() < 16) || can_pop;
        wd      = 8'(nxt);
        if (can_pop) begin
          chk("wrap_data", {24'd0, tx_data}, {24'd0, q[0]});
          void'(q.pop_front());
          pops++;
        end
        if (we) begin
          q.push_back(wd);
          nxt++;
        end
        step(we, wd, 1'b0, rdy);
        chk("wrap_level", {27'd0, level}, q.size());
        chk("wrap_empty", {31'd0, empty}, {31'd0, q.size() == 0});
        chk("wrap_full",  {31'd0, full},  {31'd0, q.size() == 16});
        cyc++;
      end
      chk("wrap_pops_done", (pops >= 70) ? 32'd1 : 32'd0, 32'd1);
    end

    // ---- asynchronous reset mid-cycle ----
    do_reset();
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 1'b0, 1'b0);
    wr_en = 1'b0;
    chk("ar_pre_level", {27'd0, level}, 32'd3);
    #3 rst = 1'b1;
    #1;
    chk("ar_valid", {31'd0, tx_data_valid}, 32'd0);
    chk("ar_empty", {31'd0, empty}, 32'd1);
    chk("ar_level", {27'd0, level}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h7E, 1'b0, 1'b0);
    chk("ar_post_valid", {31'd0, tx_data_valid}, 32'd1);
    chk("ar_post_data",  {24'd0, tx_data}, 32'h7E);

    // ---- flush with simultaneous push ----
    do_reset();
    for (int k = 0; k < 17; k++) step(1'b1, 8'h20 + 8'(k), 1'b0, 1'b0);
    for (int k = 0; k < 11; k++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("fl_pre_level", {27'd0, level}, 32'd5);
`ifdef UART_TX_FIFO_OVF_EN
    ovf_save = ovf_cnt;
    chk("fl_pre_ovf", {24'd0, ovf_save}, 32'd1);
`endif
    step(1'b1, 8'h99, 1'b1, 1'b1);
    chk("fl_empty", {31'd0, empty}, 32'd1);
    chk("fl_level", {27'd0, level}, 32'd0);
    chk("fl_valid", {31'd0, tx_data_valid}, 32'd0);
`ifdef UART_TX_FIFO_OVF_EN
    chk("fl_ovf",   {24'd0, ovf_cnt}, {24'd0, ovf_save});
`endif
    step(1'b1, 8'h66, 1'b0, 1'b0);
    chk("fl_post_data",  {24'd0, tx_data}, 32'h66);
    chk("fl_post_level", {27'd0, level}, 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("fl_post_empty", {31'd0, empty}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx_fifo
`default_nettype wire
